id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 26 ++
 rtl/id_ex_stage_hazard.sv | 28 ++
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control bundle layout, hard-zero
// register index and the per-cycle action taken by the EX register.
package id_ex_stage_pkg;

  localparam int unsigned CTRL_W = 9;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_ALUOP_LO = 5;
  localparam int unsigned CTRL_ALUOP_HI = 6;
  localparam int unsigned CTRL_UNCONDBR = 7;
  localparam int unsigned CTRL_BRANCH   = 8;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_HOLD
  } ex_act_e;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction currently in ID.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter logic [4:0] ZERO_IDX = ZERO_REG
) (
  input  logic       ex_valid_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic       id_use_rm_i,
  input  logic       id_use_rn_i,
  input  logic [4:0] id_rm_i,
  input  logic [4:0] id_rn_i,
  output logic       hazard_o
);

  logic src_match;

  always_comb begin
    src_match = (id_use_rm_i && (id_rm_i == ex_rd_i)) ||
                (id_use_rn_i && (id_rn_i == ex_rd_i));
    hazard_o  = ex_valid_i && ex_memread_i && (ex_rd_i != ZERO_IDX) &&
                id_valid_i && src_match;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush
// (deferred across memory stalls) and saturating stall counters.
module id_ex_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned CTRL_W   = id_ex_stage_pkg::CTRL_W,
  parameter logic [4:0]  ZERO_REG = id_ex_stage_pkg::ZERO_REG,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rm,
  input  logic [4:0]        id_rn,
  input  logic [4:0]        id_rd,
  input  logic              id_use_rm,
  input  logic              id_use_rn,
  input  logic [DATA_W-1:0] id_data_a,
  input  logic [DATA_W-1:0] id_data_b,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush_EX,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [4:0]        rm_EX,
  output logic [4:0]        rn_EX,
  output logic [4:0]        rd_EX,
  output logic [DATA_W-1:0] data_a_EX,
  output logic [DATA_W-1:0] data_b_EX,
  output logic [DATA_W-1:0] imm_EX,
  output logic [CTRL_W-1:0] ctrl_EX,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt
);

  id_ex_stage_pkg::ex_act_e act;

  logic              hazard_w;
  logic              flush_eff;
  logic              flush_pend_q, flush_pend_d;
  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        rm_q, rm_d, rn_q, rn_d, rd_q, rd_d;
  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d, imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  lu_cnt_q, lu_cnt_d, mem_cnt_q, mem_cnt_d;

  hazard_detect #(
    .ZERO_IDX (ZERO_REG)
  ) u_hazard (
    .ex_valid_i   (ex_valid_q),
    .ex_memread_i (ctrl_q[id_ex_stage_pkg::CTRL_MEMREAD]),
    .ex_rd_i      (rd_q),
    .id_valid_i   (id_valid),
    .id_use_rm_i  (id_use_rm),
    .id_use_rn_i  (id_use_rn),
    .id_rm_i      (id_rm),
    .id_rn_i      (id_rn),
    .hazard_o     (hazard_w)
  );

  // While in reset the front end is left free-running (act stays LOAD).
  always_comb begin
    act       = id_ex_stage_pkg::ACT_LOAD;
    flush_eff = flush_EX | flush_pend_q;
    if (!rst_n)         act = id_ex_stage_pkg::ACT_LOAD;
    else if (mem_stall) act = id_ex_stage_pkg::ACT_HOLD;
    else if (flush_eff) act = id_ex_stage_pkg::ACT_FLUSH;
    else if (hazard_w)  act = id_ex_stage_pkg::ACT_BUBBLE;
  end

  assign pc_write       = (act == id_ex_stage_pkg::ACT_LOAD) || (act == id_ex_stage_pkg::ACT_FLUSH);
  assign ifid_write     = pc_write;
  assign ifid_flush     = (act == id_ex_stage_pkg::ACT_FLUSH);
  assign load_use_stall = (act == id_ex_stage_pkg::ACT_BUBBLE);

  always_comb begin
    ex_valid_d   = ex_valid_q;
    rm_d         = rm_q;
    rn_d         = rn_q;
    rd_d         = rd_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    imm_d        = imm_q;
    ctrl_d       = ctrl_q;
    flush_pend_d = flush_pend_q;
    lu_cnt_d     = lu_cnt_q;
    mem_cnt_d    = mem_cnt_q;
    unique case (act)
      id_ex_stage_pkg::ACT_HOLD: begin
        flush_pend_d = flush_pend_q | flush_EX;
        if (mem_cnt_q != '1) mem_cnt_d = mem_cnt_q + CNT_W'(1);
      end
      id_ex_stage_pkg::ACT_FLUSH, id_ex_stage_pkg::ACT_BUBBLE: begin
        // Bubble clears control and indices only; operand data is don't-care.
        ex_valid_d   = 1'b0;
        rm_d         = '0;
        rn_d         = '0;
        rd_d         = '0;
        ctrl_d       = '0;
        flush_pend_d = 1'b0;
        if (act == id_ex_stage_pkg::ACT_BUBBLE && lu_cnt_q != '1)
          lu_cnt_d = lu_cnt_q + CNT_W'(1);
      end
      default: begin
        ex_valid_d = id_valid;
        rm_d       = id_rm;
        rn_d       = id_rn;
        rd_d       = id_rd;
        data_a_d   = id_data_a;
        data_b_d   = id_data_b;
        imm_d      = id_imm;
        ctrl_d     = id_ctrl;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      rm_q         <= '0;
      rn_q         <= '0;
      rd_q         <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      imm_q        <= '0;
      ctrl_q       <= '0;
      flush_pend_q <= 1'b0;
      lu_cnt_q     <= '0;
      mem_cnt_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      rm_q         <= rm_d;
      rn_q         <= rn_d;
      rd_q         <= rd_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      imm_q        <= imm_d;
      ctrl_q       <= ctrl_d;
      flush_pend_q <= flush_pend_d;
      lu_cnt_q     <= lu_cnt_d;
      mem_cnt_q    <= mem_cnt_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign rm_EX         = rm_q;
  assign rn_EX         = rn_q;
  assign rd_EX         = rd_q;
  assign data_a_EX     = data_a_q;
  assign data_b_EX     = data_b_q;
  assign imm_EX        = imm_q;
  assign ctrl_EX       = ctrl_q;
  assign lu_stall_cnt  = lu_cnt_q;
  assign mem_stall_cnt = mem_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each stimulus cycle queues the expected
// output snapshot; the monitor pops and compares it mid-cycle.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_valid, id_use_rm, id_use_rn, flush_EX, mem_stall;
  logic [4:0]  id_rm, id_rn, id_rd;
  logic [63:0] id_data_a, id_data_b, id_imm;
  logic [8:0]  id_ctrl;
  logic        ex_valid, pc_write, ifid_write, ifid_flush, load_use_stall;
  logic [4:0]  rm_EX, rn_EX, rd_EX;
  logic [63:0] data_a_EX, data_b_EX, imm_EX;
  logic [8:0]  ctrl_EX;
  logic [15:0] lu_stall_cnt, mem_stall_cnt;

  id_ex_stage #(.DATA_W(64), .CTRL_W(9), .ZERO_REG(5'd0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rm(id_rm), .id_rn(id_rn),
    .id_rd(id_rd), .id_use_rm(id_use_rm), .id_use_rn(id_use_rn),
    .id_data_a(id_data_a), .id_data_b(id_data_b), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .flush_EX(flush_EX), .mem_stall(mem_stall), .ex_valid(ex_valid),
    .rm_EX(rm_EX), .rn_EX(rn_EX), .rd_EX(rd_EX), .data_a_EX(data_a_EX),
    .data_b_EX(data_b_EX), .imm_EX(imm_EX), .ctrl_EX(ctrl_EX),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .load_use_stall(load_use_stall), .lu_stall_cnt(lu_stall_cnt),
    .mem_stall_cnt(mem_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] rm, rn, rd; logic urm, urn;
    logic [63:0] a, b, imm; logic [8:0] ctrl;
  } in_t;

  typedef struct {
    logic v; logic [4:0] rm, rn, rd; logic [63:0] a, b, imm; logic [8:0] ctrl;
    logic pc, ifw, fl, lus; logic [15:0] lu, ms;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic in_t mk_in(logic v, logic [4:0] rm, rn, rd, logic urm, urn,
                                logic [63:0] a, b, imm, logic [8:0] ctrl);
    in_t r;
    r.v = v; r.rm = rm; r.rn = rn; r.rd = rd; r.urm = urm; r.urn = urn;
    r.a = a; r.b = b; r.imm = imm; r.ctrl = ctrl;
    return r;
  endfunction

  function automatic exp_t mk_exp(logic v, logic [4:0] rm, rn, rd, logic [63:0] a, b, imm,
                                  logic [8:0] ctrl, logic pc, ifw, fl, lus,
                                  logic [15:0] lu, ms);
    exp_t r;
    r.v = v; r.rm = rm; r.rn = rn; r.rd = rd; r.a = a; r.b = b; r.imm = imm;
    r.ctrl = ctrl; r.pc = pc; r.ifw = ifw; r.fl = fl; r.lus = lus; r.lu = lu; r.ms = ms;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
  endtask

  task automatic drive(input in_t i, input logic fl, input logic ms, input logic rn_i);
    rst_n = rn_i; flush_EX = fl; mem_stall = ms;
    id_valid = i.v; id_rm = i.rm; id_rn = i.rn; id_rd = i.rd;
    id_use_rm = i.urm; id_use_rn = i.urn;
    id_data_a = i.a; id_data_b = i.b; id_imm = i.imm; id_ctrl = i.ctrl;
  endtask

  task automatic cyc(input in_t i, input logic fl, input logic ms, input logic rn_i,
                     input exp_t e);
    @(negedge clk);
    drive(i, fl, ms, rn_i);
    sb.push_back(e);
  endtask

  // Monitor: sample 2 time units after the falling edge, away from posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ex_valid", 64'(ex_valid), 64'(e.v));
        chk("rm_EX", 64'(rm_EX), 64'(e.rm));
        chk("rn_EX", 64'(rn_EX), 64'(e.rn));
        chk("rd_EX", 64'(rd_EX), 64'(e.rd));
        chk("data_a_EX", data_a_EX, e.a);
        chk("data_b_EX", data_b_EX, e.b);
        chk("imm_EX", imm_EX, e.imm);
        chk("ctrl_EX", 64'(ctrl_EX), 64'(e.ctrl));
        chk("pc_write", 64'(pc_write), 64'(e.pc));
        chk("ifid_write", 64'(ifid_write), 64'(e.ifw));
        chk("ifid_flush", 64'(ifid_flush), 64'(e.fl));
        chk("load_use_stall", 64'(load_use_stall), 64'(e.lus));
        chk("lu_stall_cnt", 64'(lu_stall_cnt), 64'(e.lu));
        chk("mem_stall_cnt", 64'(mem_stall_cnt), 64'(e.ms));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    in_t IDLE, LD5, ADD6, LD0, ADD9, LD3, SUB4, ADD10, ADD11, ADD12;
    IDLE  = mk_in(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    LD5   = mk_in(1, 0, 1, 5,  0, 1, 64'h100, 0, 64'h8, 9'h01B);
    ADD6  = mk_in(1, 5, 7, 6,  1, 1, 64'hAA, 64'hBB, 0, 9'h041);
    LD0   = mk_in(1, 0, 2, 0,  0, 1, 64'h200, 0, 64'h10, 9'h01B);
    ADD9  = mk_in(1, 0, 0, 9,  1, 1, 0, 0, 0, 9'h041);
    LD3   = mk_in(1, 0, 4, 3,  0, 1, 64'h300, 0, 64'h18, 9'h01B);
    SUB4  = mk_in(1, 3, 3, 4,  1, 1, 64'h33, 64'h44, 0, 9'h041);
    ADD10 = mk_in(1, 1, 2, 10, 1, 1, 64'h11, 64'h22, 0, 9'h041);
    ADD11 = mk_in(1, 1, 2, 11, 1, 1, 64'h55, 64'h66, 0, 9'h041);
    ADD12 = mk_in(1, 1, 2, 12, 1, 1, 64'h77, 64'h88, 0, 9'h041);

    drive(IDLE, 0, 0, 1);
    #1 rst_n = 1'b0;

    // Reset: front end enabled even with stall/flush requested
    cyc(IDLE, 1, 1, 0, mk_exp(0,0,0,0, 0,0,0, 0,      1,1,0,0, 0,0));
    // Load-use: LDUR X5 then ADD reading X5
    cyc(LD5,  0, 0, 1, mk_exp(0,0,0,0, 0,0,0, 0,      1,1,0,0, 0,0));
    cyc(ADD6, 0, 0, 1, mk_exp(1,0,1,5, 64'h100,0,64'h8, 9'h01B, 0,0,0,1, 0,0));
    cyc(ADD6, 0, 0, 1, mk_exp(0,0,0,0, 64'h100,0,64'h8, 0,      1,1,0,0, 1,0));
    // Load to the zero register followed by a reader of X0: no stall
    cyc(LD0,  0, 0, 1, mk_exp(1,5,7,6, 64'hAA,64'hBB,0, 9'h041, 1,1,0,0, 1,0));
    cyc(ADD9, 0, 0, 1, mk_exp(1,0,2,0, 64'h200,0,64'h10, 9'h01B, 1,1,0,0, 1,0));
    // Hazard and flush in the same cycle: flush wins, counter unchanged
    cyc(LD3,  0, 0, 1, mk_exp(1,0,0,9, 0,0,0, 9'h041,   1,1,0,0, 1,0));
    cyc(SUB4, 1, 0, 1, mk_exp(1,0,4,3, 64'h300,0,64'h18, 9'h01B, 1,1,1,0, 1,0));
    cyc(ADD10,0, 0, 1, mk_exp(0,0,0,0, 64'h300,0,64'h18, 0,      1,1,0,0, 1,0));
    // Three-cycle memory stall with flush pulsed on the second cycle
    cyc(ADD11,0, 1, 1, mk_exp(1,1,2,10, 64'h11,64'h22,0, 9'h041, 0,0,0,0, 1,0));
    cyc(ADD11,1, 1, 1, mk_exp(1,1,2,10, 64'h11,64'h22,0, 9'h041, 0,0,0,0, 1,1));
    cyc(ADD11,0, 1, 1, mk_exp(1,1,2,10, 64'h11,64'h22,0, 9'h041, 0,0,0,0, 1,2));
    cyc(ADD11,0, 0, 1, mk_exp(1,1,2,10, 64'h11,64'h22,0, 9'h041, 1,1,1,0, 1,3));
    cyc(ADD11,0, 0, 1, mk_exp(0,0,0,0,  64'h11,64'h22,0, 0,      1,1,0,0, 1,3));
    // Stall with flush pending, then asynchronous reset between edges
    cyc(ADD11,1, 1, 1, mk_exp(1,1,2,11, 64'h55,64'h66,0, 9'h041, 0,0,0,0, 1,3));
    cyc(ADD11,0, 1, 0, mk_exp(0,0,0,0,  0,0,0, 0,       1,1,0,0, 0,0));
    cyc(ADD12,0, 0, 1, mk_exp(0,0,0,0,  0,0,0, 0,       1,1,0,0, 0,0));
    cyc(IDLE, 0, 0, 1, mk_exp(1,1,2,12, 64'h77,64'h88,0, 9'h041, 1,1,0,0, 0,0));
    cyc(IDLE, 0, 0, 1, mk_exp(0,0,0,0,  0,0,0, 0,       1,1,0,0, 0,0));

    // Hazard held high for 70000 cycles: lu_stall_cnt saturates
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      if (k == 0) force dut.hazard_w = 1'b1;
      drive(IDLE, 0, 0, 1);
      if (k == 0 || k == 1 || k == 65534 || k == 65535 || k == 65536 || k == 69999)
        sb.push_back(mk_exp(0,0,0,0, 0,0,0, 0, 0,0,0,1,
                            (k >= 65535) ? 16'hFFFF : 16'(k), 0));
    end
    @(negedge clk);
    release dut.hazard_w;
    drive(IDLE, 0, 0, 1);
    sb.push_back(mk_exp(0,0,0,0, 0,0,0, 0, 1,1,0,0, 16'hFFFF, 0));

    @(negedge clk);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
